// File: rtl/rv32i_control.sv
// RV32I single-cycle decode/control: operand, writeback, memory and next-PC
// steering, plus a sticky illegal-instruction flag.
module rv32i_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_in,
  input  logic [31:0] pc,
  output logic [9:0]  alu_cid_out,
  output logic [31:0] alu_arg1_out,
  output logic [31:0] alu_arg2_out,
  input  logic [31:0] alu_arg_in,
  output logic [4:0]  reg_rd_idx1_out,
  output logic [4:0]  reg_rd_idx2_out,
  input  logic [31:0] reg_rd_data1_in,
  input  logic [31:0] reg_rd_data2_in,
  output logic        reg_wr_en_out,
  output logic [4:0]  reg_wr_idx_out,
  output logic [31:0] reg_wr_data_out,
  output logic [31:0] pc_next,
  output logic [31:0] dmem_rd_addr_out,
  input  logic [31:0] dmem_rd_data_in,
  output logic        dmem_wr_en_out,
  output logic [31:0] dmem_wr_addr_out,
  output logic [31:0] dmem_wr_data_out,
  output logic        illegal_instr_out
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [9:0] A_ADD  = 10'b00_0000_0001;
  localparam logic [9:0] A_SUB  = 10'b00_0000_0010;
  localparam logic [9:0] A_SLL  = 10'b00_0000_0100;
  localparam logic [9:0] A_SLT  = 10'b00_0000_1000;
  localparam logic [9:0] A_SLTU = 10'b00_0001_0000;
  localparam logic [9:0] A_XOR  = 10'b00_0010_0000;
  localparam logic [9:0] A_SRL  = 10'b00_0100_0000;
  localparam logic [9:0] A_SRA  = 10'b00_1000_0000;
  localparam logic [9:0] A_OR   = 10'b01_0000_0000;
  localparam logic [9:0] A_AND  = 10'b10_0000_0000;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        f7_zero;
  logic        f7_alt;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] pc_plus4;
  logic [31:0] jalr_tgt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        br_eq;
  logic        br_lt;
  logic        br_ltu;
  logic        illegal;

  assign opc     = imem_in[6:0];
  assign f3      = imem_in[14:12];
  assign f7      = imem_in[31:25];
  assign f7_zero = (f7 == 7'h00);
  assign f7_alt  = (f7 == 7'h20);

  assign imm_i = {{20{imem_in[31]}}, imem_in[31:20]};
  assign imm_s = {{20{imem_in[31]}}, imem_in[31:25], imem_in[11:7]};
  assign imm_b = {{19{imem_in[31]}}, imem_in[31], imem_in[7],
                  imem_in[30:25], imem_in[11:8], 1'b0};
  assign imm_u = {imem_in[31:12], 12'b0};
  assign imm_j = {{11{imem_in[31]}}, imem_in[31], imem_in[19:12],
                  imem_in[20], imem_in[30:21], 1'b0};

  assign pc_plus4 = pc + 32'd4;
  assign jalr_tgt = (reg_rd_data1_in + imm_i) & ~32'd1;

  assign reg_rd_idx1_out  = imem_in[19:15];
  assign reg_rd_idx2_out  = imem_in[24:20];
  assign reg_wr_idx_out   = imem_in[11:7];
  assign dmem_rd_addr_out = alu_arg_in;
  assign dmem_wr_addr_out = alu_arg_in;
  assign dmem_wr_data_out = reg_rd_data2_in;

  assign br_eq  = (reg_rd_data1_in == reg_rd_data2_in);
  assign br_lt  = ($signed(reg_rd_data1_in) < $signed(reg_rd_data2_in));
  assign br_ltu = (reg_rd_data1_in < reg_rd_data2_in);

  always_comb begin
    ld_byte = dmem_rd_data_in[7:0];
    unique case (alu_arg_in[1:0])
      2'd0: ld_byte = dmem_rd_data_in[7:0];
      2'd1: ld_byte = dmem_rd_data_in[15:8];
      2'd2: ld_byte = dmem_rd_data_in[23:16];
      2'd3: ld_byte = dmem_rd_data_in[31:24];
    endcase
    ld_half = alu_arg_in[1] ? dmem_rd_data_in[31:16]
                            : dmem_rd_data_in[15:0];
  end

  always_comb begin
    alu_cid_out     = A_ADD;
    alu_arg1_out    = reg_rd_data1_in;
    alu_arg2_out    = reg_rd_data2_in;
    reg_wr_en_out   = 1'b0;
    reg_wr_data_out = alu_arg_in;
    pc_next         = pc_plus4;
    dmem_wr_en_out  = 1'b0;
    illegal         = 1'b0;
    unique case (opc)
      OPC_OP: begin
        reg_wr_en_out = 1'b1;
        unique case (f3)
          3'b000: begin
            alu_cid_out = f7_alt ? A_SUB : A_ADD;
            illegal     = !(f7_zero || f7_alt);
          end
          3'b001: begin alu_cid_out = A_SLL;  illegal = !f7_zero; end
          3'b010: begin alu_cid_out = A_SLT;  illegal = !f7_zero; end
          3'b011: begin alu_cid_out = A_SLTU; illegal = !f7_zero; end
          3'b100: begin alu_cid_out = A_XOR;  illegal = !f7_zero; end
          3'b101: begin
            alu_cid_out = f7_alt ? A_SRA : A_SRL;
            illegal     = !(f7_zero || f7_alt);
          end
          3'b110: begin alu_cid_out = A_OR;   illegal = !f7_zero; end
          3'b111: begin alu_cid_out = A_AND;  illegal = !f7_zero; end
        endcase
      end
      OPC_OPIMM: begin
        reg_wr_en_out = 1'b1;
        alu_arg2_out  = imm_i;
        unique case (f3)
          3'b000: alu_cid_out = A_ADD;
          3'b001: begin alu_cid_out = A_SLL; illegal = !f7_zero; end
          3'b010: alu_cid_out = A_SLT;
          3'b011: alu_cid_out = A_SLTU;
          3'b100: alu_cid_out = A_XOR;
          3'b101: begin
            alu_cid_out = f7_alt ? A_SRA : A_SRL;
            illegal     = !(f7_zero || f7_alt);
          end
          3'b110: alu_cid_out = A_OR;
          3'b111: alu_cid_out = A_AND;
        endcase
      end
      OPC_LUI: begin
        reg_wr_en_out = 1'b1;
        alu_arg1_out  = 32'd0;
        alu_arg2_out  = imm_u;
      end
      OPC_AUIPC: begin
        reg_wr_en_out = 1'b1;
        alu_arg1_out  = pc;
        alu_arg2_out  = imm_u;
      end
      OPC_JAL: begin
        reg_wr_en_out   = 1'b1;
        reg_wr_data_out = pc_plus4;
        pc_next         = pc + imm_j;
      end
      OPC_JALR: begin
        reg_wr_en_out   = 1'b1;
        reg_wr_data_out = pc_plus4;
        alu_arg2_out    = imm_i;
        pc_next         = jalr_tgt;
        illegal         = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        alu_cid_out = A_SUB;
        unique case (f3)
          3'b000: if (br_eq)   pc_next = pc + imm_b;
          3'b001: if (!br_eq)  pc_next = pc + imm_b;
          3'b100: if (br_lt)   pc_next = pc + imm_b;
          3'b101: if (!br_lt)  pc_next = pc + imm_b;
          3'b110: if (br_ltu)  pc_next = pc + imm_b;
          3'b111: if (!br_ltu) pc_next = pc + imm_b;
          default: illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        reg_wr_en_out = 1'b1;
        alu_arg2_out  = imm_i;
        unique case (f3)
          3'b000: reg_wr_data_out = {{24{ld_byte[7]}}, ld_byte};
          3'b001: reg_wr_data_out = {{16{ld_half[15]}}, ld_half};
          3'b010: reg_wr_data_out = dmem_rd_data_in;
          3'b100: reg_wr_data_out = {24'd0, ld_byte};
          3'b101: reg_wr_data_out = {16'd0, ld_half};
          default: illegal = 1'b1;
        endcase
      end
      OPC_STORE: begin
        alu_arg2_out = imm_s;
        // only word stores exist; byte/half stores count as illegal
        if (f3 == 3'b010) dmem_wr_en_out = 1'b1;
        else              illegal = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      reg_wr_en_out  = 1'b0;
      dmem_wr_en_out = 1'b0;
      pc_next        = pc_plus4;
    end
    if (reg_wr_idx_out == 5'd0) reg_wr_en_out = 1'b0;
    if (rst) begin
      reg_wr_en_out  = 1'b0;
      dmem_wr_en_out = 1'b0;
      pc_next        = RESET_PC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          illegal_instr_out <= 1'b0;
    else if (illegal) illegal_instr_out <= 1'b1;
  end

endmodule

// File: tb/tb_rv32i_control.sv
// Directed bench for rv32i_control: hand-computed vectors checked with
// immediate assertions.
module tb_rv32i_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_in;
  logic [31:0] pc;
  logic [9:0]  alu_cid_out;
  logic [31:0] alu_arg1_out;
  logic [31:0] alu_arg2_out;
  logic [31:0] alu_arg_in;
  logic [4:0]  reg_rd_idx1_out;
  logic [4:0]  reg_rd_idx2_out;
  logic [31:0] reg_rd_data1_in;
  logic [31:0] reg_rd_data2_in;
  logic        reg_wr_en_out;
  logic [4:0]  reg_wr_idx_out;
  logic [31:0] reg_wr_data_out;
  logic [31:0] pc_next;
  logic [31:0] dmem_rd_addr_out;
  logic [31:0] dmem_rd_data_in;
  logic        dmem_wr_en_out;
  logic [31:0] dmem_wr_addr_out;
  logic [31:0] dmem_wr_data_out;
  logic        illegal_instr_out;

  int checks = 0;
  int failures = 0;

  rv32i_control #(.RESET_PC(32'h0000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_in           (imem_in),
    .pc                (pc),
    .alu_cid_out       (alu_cid_out),
    .alu_arg1_out      (alu_arg1_out),
    .alu_arg2_out      (alu_arg2_out),
    .alu_arg_in        (alu_arg_in),
    .reg_rd_idx1_out   (reg_rd_idx1_out),
    .reg_rd_idx2_out   (reg_rd_idx2_out),
    .reg_rd_data1_in   (reg_rd_data1_in),
    .reg_rd_data2_in   (reg_rd_data2_in),
    .reg_wr_en_out     (reg_wr_en_out),
    .reg_wr_idx_out    (reg_wr_idx_out),
    .reg_wr_data_out   (reg_wr_data_out),
    .pc_next           (pc_next),
    .dmem_rd_addr_out  (dmem_rd_addr_out),
    .dmem_rd_data_in   (dmem_rd_data_in),
    .dmem_wr_en_out    (dmem_wr_en_out),
    .dmem_wr_addr_out  (dmem_wr_addr_out),
    .dmem_wr_data_out  (dmem_wr_data_out),
    .illegal_instr_out (illegal_instr_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] alu, input logic [31:0] rd);
    @(negedge clk);
    imem_in = ins;
    pc = p;
    reg_rd_data1_in = r1;
    reg_rd_data2_in = r2;
    alu_arg_in = alu;
    dmem_rd_data_in = rd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    imem_in = 32'h0000_0013;
    pc = 32'h0000_0050;
    reg_rd_data1_in = 32'd0;
    reg_rd_data2_in = 32'd0;
    alu_arg_in = 32'd0;
    dmem_rd_data_in = 32'd0;
    @(negedge clk);
    #1;
    chk("rst_wr_en", {31'd0, reg_wr_en_out}, 32'd0);
    chk("rst_dwe", {31'd0, dmem_wr_en_out}, 32'd0);
    chk("rst_pc_next", pc_next, 32'h0);
    chk("rst_illegal", {31'd0, illegal_instr_out}, 32'd0);
    rst = 1'b0;

    // ADD x3,x1,x2
    drive(32'h002081B3, 32'h100, 32'd10, 32'd20, 32'hDEADBEEF, 32'd0);
    chk("add_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("add_wr_idx", {27'd0, reg_wr_idx_out}, 32'd3);
    chk("add_rs1_idx", {27'd0, reg_rd_idx1_out}, 32'd1);
    chk("add_rs2_idx", {27'd0, reg_rd_idx2_out}, 32'd2);
    chk("add_arg1", alu_arg1_out, 32'd10);
    chk("add_arg2", alu_arg2_out, 32'd20);
    chk("add_cid", {22'd0, alu_cid_out}, 32'h001);
    chk("add_wr_data", reg_wr_data_out, 32'hDEADBEEF);
    chk("add_pc_next", pc_next, 32'h104);
    chk("add_dwe", {31'd0, dmem_wr_en_out}, 32'd0);

    // SUB x3,x1,x2 and SRA x3,x1,x2
    drive(32'h402081B3, 32'h100, 32'd1, 32'd2, 32'd0, 32'd0);
    chk("sub_cid", {22'd0, alu_cid_out}, 32'h002);
    drive(32'h4020D1B3, 32'h100, 32'd1, 32'd2, 32'd0, 32'd0);
    chk("sra_cid", {22'd0, alu_cid_out}, 32'h080);

    // ADDI x3,x1,16
    drive(32'h01008193, 32'h104, 32'd100, 32'd999, 32'd116, 32'd0);
    chk("addi_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("addi_wr_idx", {27'd0, reg_wr_idx_out}, 32'd3);
    chk("addi_arg1", alu_arg1_out, 32'd100);
    chk("addi_arg2", alu_arg2_out, 32'd16);
    chk("addi_pc_next", pc_next, 32'h108);

    // BEQ x1,x2,0 taken then not taken
    drive(32'h00208063, 32'h108, 32'd50, 32'd50, 32'd0, 32'd0);
    chk("beq_t_pc_next", pc_next, 32'h108);
    chk("beq_wr_en", {31'd0, reg_wr_en_out}, 32'd0);
    chk("beq_dwe", {31'd0, dmem_wr_en_out}, 32'd0);
    chk("beq_cid", {22'd0, alu_cid_out}, 32'h002);
    drive(32'h00208063, 32'h108, 32'd50, 32'd51, 32'd0, 32'd0);
    chk("beq_nt_pc_next", pc_next, 32'h10C);

    // BLT / BLTU x1,x2,8 with rs1=-1, rs2=1
    drive(32'h0020C463, 32'h120, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
    chk("blt_pc_next", pc_next, 32'h128);
    drive(32'h0020E463, 32'h120, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0);
    chk("bltu_pc_next", pc_next, 32'h124);

    // JAL x1,-4
    drive(32'hFFDFF0EF, 32'h200, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("jal_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    chk("jal_wr_idx", {27'd0, reg_wr_idx_out}, 32'd1);
    chk("jal_wr_data", reg_wr_data_out, 32'h204);
    chk("jal_pc_next", pc_next, 32'h1FC);

    // JALR x5,3(x1): low bit of target cleared
    drive(32'h003082E7, 32'h300, 32'h1000, 32'd0, 32'd0, 32'd0);
    chk("jalr_pc_next", pc_next, 32'h1002);
    chk("jalr_wr_data", reg_wr_data_out, 32'h304);
    chk("jalr_wr_en", {31'd0, reg_wr_en_out}, 32'd1);

    // PC wrap
    drive(32'h00000013, 32'hFFFFFFFC, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("wrap_pc_next", pc_next, 32'h0);

    // LUI x5,0x12345
    drive(32'h123452B7, 32'h400, 32'd7, 32'd8, 32'h12345000, 32'd0);
    chk("lui_arg1", alu_arg1_out, 32'd0);
    chk("lui_arg2", alu_arg2_out, 32'h12345000);
    chk("lui_wr_en", {31'd0, reg_wr_en_out}, 32'd1);

    // ADD x0,x1,x2: no write to x0
    drive(32'h00208033, 32'h400, 32'd1, 32'd2, 32'd3, 32'd0);
    chk("x0_wr_en", {31'd0, reg_wr_en_out}, 32'd0);

    // SW x2,8(x1)
    drive(32'h0020A423, 32'h500, 32'h1000, 32'hCAFE, 32'h1008, 32'd0);
    chk("sw_dwe", {31'd0, dmem_wr_en_out}, 32'd1);
    chk("sw_addr", dmem_wr_addr_out, 32'h1008);
    chk("sw_data", dmem_wr_data_out, 32'hCAFE);
    chk("sw_arg2", alu_arg2_out, 32'd8);
    chk("sw_wr_en", {31'd0, reg_wr_en_out}, 32'd0);

    // LB / LBU / LW x3,0(x1)
    drive(32'h00008183, 32'h504, 32'h1001, 32'd0, 32'h1001, 32'h00008000);
    chk("lb_wr_data", reg_wr_data_out, 32'hFFFFFF80);
    chk("lb_rd_addr", dmem_rd_addr_out, 32'h1001);
    chk("lb_wr_en", {31'd0, reg_wr_en_out}, 32'd1);
    drive(32'h0000C183, 32'h508, 32'h1001, 32'd0, 32'h1001, 32'h00008000);
    chk("lbu_wr_data", reg_wr_data_out, 32'h00000080);
    drive(32'h0000A183, 32'h50C, 32'h1000, 32'd0, 32'h1000, 32'h00008000);
    chk("lw_wr_data", reg_wr_data_out, 32'h00008000);
    chk("pre_ill_flag", {31'd0, illegal_instr_out}, 32'd0);

    // SB x2,8(x1): unsupported, no write, flags illegal
    drive(32'h00208423, 32'h600, 32'h1000, 32'h55, 32'h1008, 32'd0);
    chk("sb_dwe", {31'd0, dmem_wr_en_out}, 32'd0);
    chk("sb_pc_next", pc_next, 32'h604);
    @(posedge clk);
    #1;
    chk("sb_ill_flag", {31'd0, illegal_instr_out}, 32'd1);

    rst = 1'b1;
    #1;
    rst = 1'b0;

    // all-ones instruction
    drive(32'hFFFFFFFF, 32'h700, 32'd1, 32'd2, 32'd3, 32'd0);
    chk("ill_wr_en", {31'd0, reg_wr_en_out}, 32'd0);
    chk("ill_dwe", {31'd0, dmem_wr_en_out}, 32'd0);
    chk("ill_pc_next", pc_next, 32'h704);
    chk("ill_pre_edge", {31'd0, illegal_instr_out}, 32'd0);
    @(posedge clk);
    #1;
    chk("ill_flag", {31'd0, illegal_instr_out}, 32'd1);
    drive(32'h00000013, 32'h704, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk("ill_sticky", {31'd0, illegal_instr_out}, 32'd1);
    rst = 1'b1;
    #1;
    chk("ill_rst_flag", {31'd0, illegal_instr_out}, 32'd0);
    chk("ill_rst_pc_next", pc_next, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_control.md
Name: rv32i_control

Overview:
- Combinational RV32I single-cycle decode/control unit. Sits between instruction memory, register file, ALU and data memory.
- Decodes `imem_in` and selects the register read indices, ALU operands and operation.
- Steers the writeback data, data-memory access and next-PC.
- One clocked element: a sticky illegal-instruction flag.

Parameters:
- RESET_PC, 32'h0000_0000, value driven on `pc_next` while `rst` is high.

Ports:
- clk  in  1  clock; updates only the illegal flag.
- rst  in  1  asynchronous, active-high reset.
- imem_in  in  32  current instruction.
- pc  in  32  current PC.
- alu_cid_out  out  10  one-hot ALU op. Bit order: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- alu_arg1_out  out  32  ALU operand 1.
- alu_arg2_out  out  32  ALU operand 2.
- alu_arg_in  in  32  ALU result.
- reg_rd_idx1_out  out  5  rs1 index, always `imem_in[19:15]`.
- reg_rd_idx2_out  out  5  rs2 index, always `imem_in[24:20]`.
- reg_rd_data1_in  in  32  rs1 value.
- reg_rd_data2_in  in  32  rs2 value.
- reg_wr_en_out  out  1  register write enable.
- reg_wr_idx_out  out  5  rd index, always `imem_in[11:7]`.
- reg_wr_data_out  out  32  writeback data.
- pc_next  out  32  next PC.
- dmem_rd_addr_out  out  32  load address.
- dmem_rd_data_in  in  32  load data (word).
- dmem_wr_en_out  out  1  store enable.
- dmem_wr_addr_out  out  32  store address.
- dmem_wr_data_out  out  32  store data.
- illegal_instr_out  out  1  sticky illegal-opcode flag.

Behaviour:
- All outputs except `illegal_instr_out` are purely combinational from the inputs; no latency.
- `rst` high (asynchronous):
  - `reg_wr_en_out` = 0, `dmem_wr_en_out` = 0, `pc_next` = RESET_PC.
  - `illegal_instr_out` cleared to 0.
- `illegal_instr_out`: set on rising `clk` when the current instruction is illegal; held until `rst`.
- Immediates are sign-extended to 32 bits: I `[31:20]`, S `{[31:25],[11:7]}`, B `{[31],[7],[30:25],[11:8],0}`, U `{[31:12],12'b0}`, J `{[31],[19:12],[20],[30:21],0}`.
- Default for every instruction:
  - `pc_next` = pc+4 (wraps mod 2^32).
  - `reg_wr_en_out` = 0, `dmem_wr_en_out` = 0.
  - ALU op = ADD, arg1 = rs1 data, arg2 = rs2 data.
  - `dmem_rd_addr_out`, `dmem_wr_addr_out` = `alu_arg_in`; `dmem_wr_data_out` = rs2 data.
- OP (0110011): ALU op from funct3 plus funct7[5] (SUB, SRA). Write enable = 1; writeback data = `alu_arg_in`.
- OP-IMM (0010011): arg2 = I-immediate. Shifts use funct7[5] to select SRA; no SUBI. Write enable = 1; writeback data = `alu_arg_in`.
- LUI: arg1 = 0, arg2 = U-immediate, ADD, writeback data = `alu_arg_in`.
- AUIPC: arg1 = pc, arg2 = U-immediate, ADD, writeback data = `alu_arg_in`.
- JAL: writeback data = pc+4, write enable = 1, `pc_next` = pc + J-immediate.
- JALR: writeback data = pc+4, `pc_next` = (rs1 + I-immediate) & ~1, computed internally.
- BRANCH: arg1 = rs1, arg2 = rs2, ALU op SUB.
  - Condition is evaluated internally from `reg_rd_data1_in`/`reg_rd_data2_in`: BEQ, BNE, BLT/BGE signed, BLTU/BGEU unsigned.
  - Taken: `pc_next` = pc + B-immediate; not taken: pc+4.
- LOAD: arg2 = I-immediate, ADD, write enable = 1.
  - The selected byte/half is taken from `dmem_rd_data_in` using `alu_arg_in[1:0]`.
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- STORE: arg2 = S-immediate, ADD.
  - SW sets `dmem_wr_en_out` = 1.
  - SB/SH are unsupported: treated as illegal, no write.
- FENCE, ECALL, EBREAK (opcodes 0001111, 1110011): no-op, pc+4.
- Illegal (any other opcode, invalid funct3/funct7, or SB/SH): no writes, pc+4, sets the illegal flag.
- rd = x0: `reg_wr_en_out` forced to 0.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), pc=0x100, rs1=10, rs2=20, alu_arg_in=0xDEADBEEF -> wr_en=1, wr_idx=3, arg1=10, arg2=20, cid=0x001, wr_data=0xDEADBEEF, pc_next=0x104.
- ADDI x3,x1,16 (0x01008193), pc=0x104, rs1=100, rs2=999 -> wr_en=1, wr_idx=3, arg1=100, arg2=16, pc_next=0x108.
- BEQ x1,x2,0 (0x00208063), pc=0x108, rs1=rs2=50 -> pc_next=0x108, no writes; with rs2=51 -> pc_next=0x10C.
- JAL x1,-4 (0xFFDFF0EF), pc=0x200 -> wr_en=1, wr_idx=1, wr_data=0x204, pc_next=0x1FC.
- SW x2,8(x1) (0x0020A423), alu_arg_in=0x1008, rs2=0xCAFE -> dmem_wr_en=1, wr_addr=0x1008, wr_data=0xCAFE, reg_wr_en=0; then LB with dmem_rd_data_in=0x0000_8000 and alu_arg_in[1:0]=1 -> wr_data=0xFFFFFF80.
- imem_in=0xFFFFFFFF, then clk edge -> no writes, pc_next=pc+4, illegal_instr_out=1; assert rst -> illegal_instr_out=0 and pc_next=RESET_PC immediately.
